// File: rtl/decode_regfile_sb_pkg.sv
// Shared widths, the hardwired-zero register index and the read-port slice helper
// for the decode-stage register file with divider scoreboard.
package decode_regfile_sb_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned DEF_NRD    = 2;
    localparam int unsigned ZERO_REG   = 0;

    // LSB of port `port` inside a flattened vector of `width`-bit fields
    function automatic int unsigned port_lsb(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/decode_regfile_sb_if.sv
// Bundle of read, write, issue and status signals between the D stage and the register file.
interface decode_regfile_sb_if #(
    parameter int unsigned DATA_W = decode_regfile_sb_pkg::DEF_DATA_W,
    parameter int unsigned ADDR_W = decode_regfile_sb_pkg::DEF_ADDR_W,
    parameter int unsigned NRD    = decode_regfile_sb_pkg::DEF_NRD
);
    logic [NRD*ADDR_W-1:0] rd_addr;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_busy;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic                  lw_en;
    logic [ADDR_W-1:0]     lw_addr;
    logic [DATA_W-1:0]     lw_data;
    logic                  iss_en;
    logic [ADDR_W-1:0]     iss_addr;
    logic                  iss_ready;
    logic                  clear_all;
    logic [ADDR_W:0]       pend_cnt;
    logic                  err_waw;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, lw_en, lw_addr, lw_data,
               iss_en, iss_addr, clear_all,
        input  rd_data, rd_busy, iss_ready, pend_cnt, err_waw
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, lw_en, lw_addr, lw_data,
               iss_en, iss_addr, clear_all,
        output rd_data, rd_busy, iss_ready, pend_cnt, err_waw
    );
endinterface

// File: rtl/decode_regfile_sb_scoreboard.sv
// Busy scoreboard for outstanding divider results: hazard flags, issue acceptance
// and a registered count of pending registers.
module decode_regfile_sb_scoreboard
    import decode_regfile_sb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned NRD    = DEF_NRD
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    input  logic                  iss_en,
    input  logic [ADDR_W-1:0]     iss_addr,
    input  logic                  lw_en,
    input  logic [ADDR_W-1:0]     lw_addr,
    input  logic                  clear_all,
    output logic [NRD-1:0]        rd_busy,
    output logic                  iss_ready,
    output logic [ADDR_W:0]       pend_cnt
);
    localparam int unsigned NREG  = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [ADDR_W-1:0] port_addr [NRD];

    // A divider result landing this cycle resolves the WAW stall on its destination
    assign iss_ready = (iss_addr == ADDR_W'(ZERO_REG)) || !busy[iss_addr]
                       || (lw_en && (lw_addr == iss_addr));

    always_comb begin
        rd_busy = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            port_addr[i] = rd_addr[port_lsb(i, ADDR_W) +: ADDR_W];
            rd_busy[i]   = busy[port_addr[i]] && !(lw_en && (lw_addr == port_addr[i]));
        end
    end

    // Abort wins outright; an accepted issue is applied after the writeback clear so it wins
    always_comb begin
        busy_nxt = busy;
        cnt_nxt  = '0;
        if (clear_all) begin
            busy_nxt = '0;
        end else begin
            if (lw_en) begin
                busy_nxt[lw_addr] = 1'b0;
            end
            if (iss_en && iss_ready && (iss_addr != ADDR_W'(ZERO_REG))) begin
                busy_nxt[iss_addr] = 1'b1;
            end
        end
        for (int unsigned r = 0; r < NREG; r++) begin
            cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[r]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy     <= '0;
            pend_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/decode_regfile_sb.sv
// Decode-stage register file: storage, two write ports, bypassed combinational reads,
// with the divider busy scoreboard alongside.
module decode_regfile_sb
    import decode_regfile_sb_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned NRD    = DEF_NRD
) (
    input logic                 clk,
    input logic                 reset,
    decode_regfile_sb_if.slave  bus
);
    localparam int unsigned NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [ADDR_W-1:0] rd_a [NRD];

    // W-stage data wins when both ports target the same register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int unsigned r = 1; r < NREG; r++) begin
                if (bus.wr_en && (bus.wr_addr == ADDR_W'(r))) begin
                    regs[r] <= bus.wr_data;
                end else if (bus.lw_en && (bus.lw_addr == ADDR_W'(r))) begin
                    regs[r] <= bus.lw_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.err_waw <= 1'b0;
        end else if (bus.wr_en && bus.lw_en && (bus.wr_addr == bus.lw_addr)
                     && (bus.wr_addr != ADDR_W'(ZERO_REG))) begin
            bus.err_waw <= 1'b1;
        end
    end

    // Read ports: zero register, then W-stage bypass, then divider bypass, then storage
    always_comb begin
        bus.rd_data = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            rd_a[i] = bus.rd_addr[port_lsb(i, ADDR_W) +: ADDR_W];
            if (rd_a[i] == ADDR_W'(ZERO_REG)) begin
                bus.rd_data[port_lsb(i, DATA_W) +: DATA_W] = '0;
            end else if (bus.wr_en && (bus.wr_addr == rd_a[i])) begin
                bus.rd_data[port_lsb(i, DATA_W) +: DATA_W] = bus.wr_data;
            end else if (bus.lw_en && (bus.lw_addr == rd_a[i])) begin
                bus.rd_data[port_lsb(i, DATA_W) +: DATA_W] = bus.lw_data;
            end else begin
                bus.rd_data[port_lsb(i, DATA_W) +: DATA_W] = regs[rd_a[i]];
            end
        end
    end

    decode_regfile_sb_scoreboard #(
        .ADDR_W (ADDR_W),
        .NRD    (NRD)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (bus.rd_addr),
        .iss_en    (bus.iss_en),
        .iss_addr  (bus.iss_addr),
        .lw_en     (bus.lw_en),
        .lw_addr   (bus.lw_addr),
        .clear_all (bus.clear_all),
        .rd_busy   (bus.rd_busy),
        .iss_ready (bus.iss_ready),
        .pend_cnt  (bus.pend_cnt)
    );

endmodule

// File: tb/tb_decode_regfile_sb.sv
// Bench for decode_regfile_sb: directed vector table, mid-operation async reset,
// then random traffic checked against a register/busy-set reference model.
module tb_decode_regfile_sb;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    decode_regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .NRD(2)) bus ();

    decode_regfile_sb #(.DATA_W(32), .ADDR_W(5), .NRD(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
        logic        lw_en;
        logic [4:0]  lw_addr;
        logic [31:0] lw_data;
        logic        iss_en;
        logic [4:0]  iss_addr;
        logic        clear_all;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  busy;
        logic        ready;
        logic [5:0]  pend;
        logic        err;
    } vec_t;

    int passed = 0;
    int total  = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_busy;
    logic        m_err;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    endtask

    function automatic stim_t st(logic we, logic [4:0] wa, logic [31:0] wd,
                                 logic le, logic [4:0] la, logic [31:0] ld,
                                 logic ie, logic [4:0] ia, logic ca,
                                 logic [4:0] r0, logic [4:0] r1);
        stim_t s;
        s.wr_en = we; s.wr_addr = wa; s.wr_data = wd;
        s.lw_en = le; s.lw_addr = la; s.lw_data = ld;
        s.iss_en = ie; s.iss_addr = ia; s.clear_all = ca;
        s.ra0 = r0; s.ra1 = r1;
        return s;
    endfunction

    function automatic void m_reset();
        for (int r = 0; r < 32; r++) m_regs[r] = '0;
        m_busy = '0;
        m_err  = 1'b0;
    endfunction

    function automatic logic [31:0] m_read(stim_t s, logic [4:0] a);
        if (a == 0) return '0;
        if (s.wr_en && s.wr_addr == a) return s.wr_data;
        if (s.lw_en && s.lw_addr == a) return s.lw_data;
        return m_regs[a];
    endfunction

    function automatic logic m_rbusy(stim_t s, logic [4:0] a);
        return m_busy[a] && !(s.lw_en && s.lw_addr == a);
    endfunction

    function automatic logic m_ready(stim_t s);
        return (s.iss_addr == 0) || !m_busy[s.iss_addr] || (s.lw_en && s.lw_addr == s.iss_addr);
    endfunction

    function automatic void m_update(stim_t s);
        logic acc;
        acc = s.iss_en && m_ready(s);
        if (s.wr_en && s.lw_en && s.wr_addr == s.lw_addr && s.wr_addr != 0) m_err = 1'b1;
        if (s.lw_en && s.lw_addr != 0) m_regs[s.lw_addr] = s.lw_data;
        if (s.wr_en && s.wr_addr != 0) m_regs[s.wr_addr] = s.wr_data;
        if (s.clear_all) begin
            m_busy = '0;
        end else begin
            if (s.lw_en) m_busy[s.lw_addr] = 1'b0;
            if (acc && s.iss_addr != 0) m_busy[s.iss_addr] = 1'b1;
        end
    endfunction

    task automatic drive(input stim_t s);
        bus.wr_en = s.wr_en; bus.wr_addr = s.wr_addr; bus.wr_data = s.wr_data;
        bus.lw_en = s.lw_en; bus.lw_addr = s.lw_addr; bus.lw_data = s.lw_data;
        bus.iss_en = s.iss_en; bus.iss_addr = s.iss_addr; bus.clear_all = s.clear_all;
        bus.rd_addr = {s.ra1, s.ra0};
    endtask

    // One cycle: combinational checks before the edge, registered checks just after it
    task automatic run(input vec_t v, input bit from_model);
        vec_t e;
        e = v;
        drive(v.s);
        #2;
        if (from_model) begin
            e.d0    = m_read(v.s, v.s.ra0);
            e.d1    = m_read(v.s, v.s.ra1);
            e.busy  = {m_rbusy(v.s, v.s.ra1), m_rbusy(v.s, v.s.ra0)};
            e.ready = m_ready(v.s);
        end
        chk("rd_data0", 64'(bus.rd_data[31:0]), 64'(e.d0));
        chk("rd_data1", 64'(bus.rd_data[63:32]), 64'(e.d1));
        chk("rd_busy", 64'(bus.rd_busy), 64'(e.busy));
        chk("iss_ready", 64'(bus.iss_ready), 64'(e.ready));
        @(posedge clk);
        m_update(v.s);
        #1;
        if (from_model) begin
            e.pend = 6'($countones(m_busy));
            e.err  = m_err;
        end
        chk("pend_cnt", 64'(bus.pend_cnt), 64'(e.pend));
        chk("err_waw", 64'(bus.err_waw), 64'(e.err));
    endtask

    vec_t tbl [19];
    vec_t rv;

    initial begin
        //                 we wa  wd            le la  ld            ie ia  ca r0  r1
        tbl[0]  = '{st(0, 0, 0,            0, 0, 0,            0, 0,  0, 0,  0),  0, 0, 2'b00, 1, 0, 0};
        tbl[1]  = '{st(1, 5, 32'h12345678, 0, 0, 0,            0, 0,  0, 5,  5),  32'h12345678, 32'h12345678, 2'b00, 1, 0, 0};
        tbl[2]  = '{st(0, 0, 0,            0, 0, 0,            0, 0,  0, 5,  0),  32'h12345678, 0, 2'b00, 1, 0, 0};
        tbl[3]  = '{st(1, 0, 32'hFFFFFFFF, 0, 0, 0,            0, 0,  0, 0,  0),  0, 0, 2'b00, 1, 0, 0};
        tbl[4]  = '{st(0, 0, 0,            0, 0, 0,            0, 0,  0, 0,  5),  0, 32'h12345678, 2'b00, 1, 0, 0};
        tbl[5]  = '{st(0, 0, 0,            0, 0, 0,            1, 8,  0, 0,  8),  0, 0, 2'b00, 1, 1, 0};
        tbl[6]  = '{st(0, 0, 0,            0, 0, 0,            1, 8,  0, 0,  8),  0, 0, 2'b10, 0, 1, 0};
        tbl[7]  = '{st(0, 0, 0,            1, 8, 32'hA5A5A5A5, 0, 0,  0, 0,  8),  0, 32'hA5A5A5A5, 2'b00, 1, 0, 0};
        tbl[8]  = '{st(0, 0, 0,            0, 0, 0,            0, 0,  0, 0,  8),  0, 32'hA5A5A5A5, 2'b00, 1, 0, 0};
        tbl[9]  = '{st(0, 0, 0,            0, 0, 0,            1, 3,  0, 0,  0),  0, 0, 2'b00, 1, 1, 0};
        tbl[10] = '{st(0, 0, 0,            1, 3, 32'h33,       1, 3,  0, 3,  0),  32'h33, 0, 2'b00, 1, 1, 0};
        tbl[11] = '{st(0, 0, 0,            0, 0, 0,            0, 0,  0, 3,  0),  32'h33, 0, 2'b01, 1, 1, 0};
        tbl[12] = '{st(0, 0, 0,            1, 3, 32'h44,       0, 0,  0, 3,  0),  32'h44, 0, 2'b00, 1, 0, 0};
        tbl[13] = '{st(1, 9, 32'h1,        1, 9, 32'h2,        0, 0,  0, 9,  0),  32'h1, 0, 2'b00, 1, 0, 1};
        tbl[14] = '{st(0, 0, 0,            0, 0, 0,            0, 0,  0, 9,  0),  32'h1, 0, 2'b00, 1, 0, 1};
        tbl[15] = '{st(0, 0, 0,            0, 0, 0,            1, 4,  0, 0,  0),  0, 0, 2'b00, 1, 1, 1};
        tbl[16] = '{st(0, 0, 0,            0, 0, 0,            1, 7,  0, 4,  0),  0, 0, 2'b01, 1, 2, 1};
        tbl[17] = '{st(0, 0, 0,            0, 0, 0,            1, 10, 1, 4,  7),  0, 0, 2'b11, 1, 0, 1};
        tbl[18] = '{st(0, 0, 0,            0, 0, 0,            0, 0,  0, 10, 5),  0, 32'h12345678, 2'b00, 1, 0, 1};

        drive(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0));
        m_reset();
        #12;
        chk("rst_rd_data0", 64'(bus.rd_data[31:0]), 64'h0);
        chk("rst_rd_busy", 64'(bus.rd_busy), 64'h0);
        chk("rst_pend_cnt", 64'(bus.pend_cnt), 64'h0);
        chk("rst_iss_ready", 64'(bus.iss_ready), 64'h1);
        chk("rst_err_waw", 64'(bus.err_waw), 64'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 19; i++) run(tbl[i], 1'b0);

        // Asynchronous reset with a divider op outstanding and err_waw set
        run('{st(0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0), 0, 0, 0, 0, 0, 0}, 1'b1);
        run('{st(1, 5, 32'hDEAD, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0}, 1'b1);
        drive(st(0, 0, 0, 0, 0, 0, 0, 4, 0, 5, 4));
        #2;
        chk("pre_rst_rd_busy", 64'(bus.rd_busy), 64'h2);
        chk("pre_rst_iss_ready", 64'(bus.iss_ready), 64'h0);
        chk("pre_rst_rd_data0", 64'(bus.rd_data[31:0]), 64'hDEAD);
        #1;
        reset = 1'b0;
        #1;
        chk("async_rst_rd_data0", 64'(bus.rd_data[31:0]), 64'h0);
        chk("async_rst_rd_busy", 64'(bus.rd_busy), 64'h0);
        chk("async_rst_iss_ready", 64'(bus.iss_ready), 64'h1);
        chk("async_rst_pend_cnt", 64'(bus.pend_cnt), 64'h0);
        chk("async_rst_err_waw", 64'(bus.err_waw), 64'h0);
        m_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic on a narrow address window to provoke collisions and hazards
        for (int n = 0; n < 600; n++) begin
            rv.s = st(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                      1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
                      1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                      1'($urandom_range(0, 19) == 0),
                      5'($urandom_range(0, 9)), 5'($urandom_range(0, 31)));
            run(rv, 1'b1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
